conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer -- address/control sequencer for a convolution accelerator.
//
// After a trigger, walks the output grid (stride s, raster order) and, for each
// output pixel, issues one MAC tap per filter element (depth innermost, then
// filter x, then filter y). Taps that fall outside the image are flagged as
// padding. Once the MAC datapath returns the accumulated sum, the biased result
// is written to output memory and the next pixel starts.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   trigger_accel               one-cycle start pulse (ignored while busy)
//   image_dim, image_depth      image width/height in pixels, channels per pixel
//   *_memory_offset             base addresses of image, filter and output
//   filter_halfsize             h; filter is (2h+1)x(2h+1)xdepth
//   filter_stride               output stride (0 behaves as 1)
//   filter_bias                 added to every output word
//   mac_valid/mac_ready         tap handshake
//   mac_image_addr/filter_addr  tap addresses; mac_pad marks out-of-image taps
//   mac_first, mac_last         first/last tap of an output pixel
//   result_valid, result_data   accumulated sum for the current pixel
//   mem_write_*                 output memory write port
//   busy, done                  run in progress / one-cycle completion pulse
module conv_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger_accel,
    input  logic [7:0]        image_dim,
    input  logic [8:0]        image_depth,
    input  logic [ADDR_W-1:0] image_memory_offset,
    input  logic [ADDR_W-1:0] filter_memory_offset,
    input  logic [ADDR_W-1:0] output_memory_offset,
    input  logic [1:0]        filter_halfsize,
    input  logic [2:0]        filter_stride,
    input  logic [DATA_W-1:0] filter_bias,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [ADDR_W-1:0] mac_image_addr,
    output logic [ADDR_W-1:0] mac_filter_addr,
    output logic              mac_pad,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result_data,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Signed coordinates: 11 bits hold 255 + stride and -3 without wrapping.
    typedef logic signed [10:0] coord_t;

    state_t state_q, state_d;

    // Configuration captured at trigger accept.
    logic [7:0]        dim_q;
    logic [8:0]        depth_q;
    logic [ADDR_W-1:0] img_off_q;
    logic [ADDR_W-1:0] flt_off_q;
    logic [ADDR_W-1:0] out_off_q;
    logic [1:0]        h_q;
    logic [2:0]        stride_q;
    logic [DATA_W-1:0] bias_q;

    // Walk counters.
    coord_t            ox_q, oy_q;
    coord_t            fx_q, fy_q;
    logic [8:0]        d_q;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] n_q;
    logic [DATA_W-1:0] res_q;

    // Derived values.
    coord_t            h_pos, h_in, dim_s, stride_s;
    coord_t            iy, ix, ox_next, oy_next;
    logic              in_bounds, d_last, tap_last, row_end, grid_end;
    logic [ADDR_W-1:0] pix_lin, img_addr;

    assign h_pos    = {9'd0, h_q};
    assign h_in     = {9'd0, filter_halfsize};
    assign dim_s    = {3'd0, dim_q};
    assign stride_s = {8'd0, stride_q};

    assign iy = oy_q + fy_q;
    assign ix = ox_q + fx_q;
    assign in_bounds = (iy >= 0) && (ix >= 0) && (iy < dim_s) && (ix < dim_s);

    // Only meaningful when in bounds; arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        pix_lin  = ADDR_W'(iy[9:0]) * ADDR_W'(dim_q) + ADDR_W'(ix[9:0]);
        img_addr = img_off_q + pix_lin * ADDR_W'(depth_q) + ADDR_W'(d_q);
    end

    assign d_last   = (d_q == depth_q - 9'd1);
    assign tap_last = (fy_q == h_pos) && (fx_q == h_pos) && d_last;

    assign ox_next  = ox_q + stride_s;
    assign oy_next  = oy_q + stride_s;
    assign row_end  = (ox_next >= dim_s);
    assign grid_end = (oy_next >= dim_s);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next state and outputs. All outputs are decoded from registered state,
    // so reset zeroes them in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d         = state_q;
        mac_valid       = 1'b0;
        mac_image_addr  = '0;
        mac_filter_addr = '0;
        mac_pad         = 1'b0;
        mac_first       = 1'b0;
        mac_last        = 1'b0;
        mem_write_en    = 1'b0;
        mem_write_addr  = '0;
        mem_write_data  = '0;
        busy            = (state_q != S_IDLE);
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger_accel) begin
                    if (image_dim == 8'd0 || image_depth == 9'd0) state_d = S_DONE;
                    else                                          state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mac_valid       = 1'b1;
                mac_pad         = !in_bounds;
                mac_image_addr  = in_bounds ? img_addr : '0;
                mac_filter_addr = flt_off_q + k_q;
                mac_first       = (k_q == '0);
                mac_last        = tap_last;
                if (mac_ready && tap_last) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (result_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_write_en   = 1'b1;
                mem_write_addr = out_off_q + n_q;
                mem_write_data = res_q + bias_q;
                if (row_end && grid_end) state_d = S_DONE;
                else                     state_d = S_ISSUE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration capture and walk counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_q     <= '0;
            depth_q   <= '0;
            img_off_q <= '0;
            flt_off_q <= '0;
            out_off_q <= '0;
            h_q       <= '0;
            stride_q  <= '0;
            bias_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            d_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger_accel) begin
                        dim_q     <= image_dim;
                        depth_q   <= image_depth;
                        img_off_q <= image_memory_offset;
                        flt_off_q <= filter_memory_offset;
                        out_off_q <= output_memory_offset;
                        h_q       <= filter_halfsize;
                        stride_q  <= (filter_stride == 3'd0) ? 3'd1 : filter_stride;
                        bias_q    <= filter_bias;
                        ox_q      <= '0;
                        oy_q      <= '0;
                        fy_q      <= -h_in;
                        fx_q      <= -h_in;
                        d_q       <= '0;
                        k_q       <= '0;
                        n_q       <= '0;
                    end
                end
                S_ISSUE: begin
                    if (mac_ready) begin
                        if (tap_last) begin
                            // Rewind the filter walk for the next output pixel.
                            k_q  <= '0;
                            d_q  <= '0;
                            fy_q <= -h_pos;
                            fx_q <= -h_pos;
                        end else begin
                            k_q <= k_q + ADDR_W'(1);
                            if (d_last) begin
                                d_q <= '0;
                                if (fx_q == h_pos) begin
                                    fx_q <= -h_pos;
                                    fy_q <= fy_q + 11'sd1;
                                end else begin
                                    fx_q <= fx_q + 11'sd1;
                                end
                            end else begin
                                d_q <= d_q + 9'd1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (result_valid) res_q <= result_data;
                end
                S_WRITE: begin
                    n_q <= n_q + ADDR_W'(1);
                    if (row_end) begin
                        ox_q <= '0;
                        oy_q <= oy_next;
                    end else begin
                        ox_q <= ox_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: randomized handshakes and
// configurations compared against a nested-loop reference model of the
// convolution walk.
module tb_conv_sequencer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 18;
    localparam int AMASK  = (1 << ADDR_W) - 1;
    localparam int DMASK  = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              trigger_accel = 1'b0;
    logic [7:0]        image_dim = '0;
    logic [8:0]        image_depth = '0;
    logic [ADDR_W-1:0] image_memory_offset = '0;
    logic [ADDR_W-1:0] filter_memory_offset = '0;
    logic [ADDR_W-1:0] output_memory_offset = '0;
    logic [1:0]        filter_halfsize = '0;
    logic [2:0]        filter_stride = '0;
    logic [DATA_W-1:0] filter_bias = '0;
    logic              mac_valid;
    logic              mac_ready = 1'b0;
    logic [ADDR_W-1:0] mac_image_addr;
    logic [ADDR_W-1:0] mac_filter_addr;
    logic              mac_pad, mac_first, mac_last;
    logic              result_valid = 1'b0;
    logic [DATA_W-1:0] result_data = '0;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              busy, done;

    always #5 clk = ~clk;

    conv_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .trigger_accel        (trigger_accel),
        .image_dim            (image_dim),
        .image_depth          (image_depth),
        .image_memory_offset  (image_memory_offset),
        .filter_memory_offset (filter_memory_offset),
        .output_memory_offset (output_memory_offset),
        .filter_halfsize      (filter_halfsize),
        .filter_stride        (filter_stride),
        .filter_bias          (filter_bias),
        .mac_valid            (mac_valid),
        .mac_ready            (mac_ready),
        .mac_image_addr       (mac_image_addr),
        .mac_filter_addr      (mac_filter_addr),
        .mac_pad              (mac_pad),
        .mac_first            (mac_first),
        .mac_last             (mac_last),
        .result_valid         (result_valid),
        .result_data          (result_data),
        .mem_write_en         (mem_write_en),
        .mem_write_addr       (mem_write_addr),
        .mem_write_data       (mem_write_data),
        .busy                 (busy),
        .done                 (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int img;
        int flt;
        bit pad;
        bit first;
        bit last;
    } tap_t;

    tap_t exp_taps[$];
    int   exp_wdata[$];

    // Reference model: the full tap stream of a run, as nested loops over
    // output pixel, filter row, filter column and channel. Returns the number
    // of output words.
    function automatic int build_model(input int dim, input int depth, input int h,
                                       input int s, input int img_off, input int flt_off);
        int se;
        int n_out;
        se = (s == 0) ? 1 : s;
        n_out = 0;
        exp_taps.delete();
        if (dim == 0 || depth == 0) return 0;
        for (int oy = 0; oy < dim; oy += se) begin
            for (int ox = 0; ox < dim; ox += se) begin
                int k;
                k = 0;
                for (int fy = -h; fy <= h; fy++) begin
                    for (int fx = -h; fx <= h; fx++) begin
                        for (int d = 0; d < depth; d++) begin
                            tap_t t;
                            int iy, ix;
                            iy = oy + fy;
                            ix = ox + fx;
                            t.pad   = !(iy >= 0 && iy < dim && ix >= 0 && ix < dim);
                            t.img   = t.pad ? 0 : (img_off + (iy * dim + ix) * depth + d) & AMASK;
                            t.flt   = (flt_off + k) & AMASK;
                            t.first = (k == 0);
                            t.last  = (fy == h && fx == h && d == depth - 1);
                            exp_taps.push_back(t);
                            k++;
                        end
                    end
                end
                n_out++;
            end
        end
        return n_out;
    endfunction

    // ready_mode: 0 always ready, 1 toggling, 2 random.
    // res_mode:   0 result = taps per pixel, 1 random, 2 all ones.
    task automatic run_case(input string name, input int dim, input int depth, input int h,
                            input int s, input int ready_mode, input int res_mode,
                            input int bias_v);
        int  img_off, flt_off, out_off;
        int  n_out, n_written, cycles, wait_cnt, tpp, res;
        bit  waiting, seen_done;
        tap_t t;

        img_off   = $urandom_range(0, AMASK);
        flt_off   = $urandom_range(0, AMASK);
        out_off   = $urandom_range(0, AMASK);
        n_out     = build_model(dim, depth, h, s, img_off, flt_off);
        tpp       = (2 * h + 1) * (2 * h + 1) * depth;
        exp_wdata.delete();
        n_written = 0;
        cycles    = 0;
        wait_cnt  = 0;
        waiting   = 1'b0;
        seen_done = 1'b0;

        @(negedge clk);
        image_dim            = 8'(dim);
        image_depth          = 9'(depth);
        filter_halfsize      = 2'(h);
        filter_stride        = 3'(s);
        filter_bias          = DATA_W'(bias_v);
        image_memory_offset  = ADDR_W'(img_off);
        filter_memory_offset = ADDR_W'(flt_off);
        output_memory_offset = ADDR_W'(out_off);
        trigger_accel        = 1'b1;
        @(negedge clk);
        trigger_accel = 1'b0;
        // Configuration must have been captured; disturb the inputs.
        image_dim            = 8'($urandom);
        image_depth          = 9'($urandom);
        filter_halfsize      = 2'($urandom);
        filter_stride        = 3'($urandom);
        filter_bias          = DATA_W'($urandom);
        image_memory_offset  = ADDR_W'($urandom);
        filter_memory_offset = ADDR_W'($urandom);
        output_memory_offset = ADDR_W'($urandom);

        while (!seen_done && cycles < 30000) begin
            case (ready_mode)
                0:       mac_ready = 1'b1;
                1:       mac_ready = !mac_ready;
                default: mac_ready = 1'($urandom_range(0, 1));
            endcase
            result_valid = 1'b0;
            result_data  = DATA_W'($urandom);
            if (waiting) begin
                if (wait_cnt == 0) begin
                    case (res_mode)
                        0:       res = tpp;
                        1:       res = int'($urandom) & DMASK;
                        default: res = DMASK;
                    endcase
                    result_valid = 1'b1;
                    result_data  = DATA_W'(res);
                    exp_wdata.push_back((res + bias_v) & DMASK);
                    waiting = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                result_valid = 1'b1;
            end
            trigger_accel = ($urandom_range(0, 15) == 0);

            check({name, ".busy"}, busy, 1);
            if (mac_valid) begin
                if (exp_taps.size() == 0) begin
                    check({name, ".extra_tap"}, 1, 0);
                end else begin
                    t = exp_taps[0];
                    check({name, ".img_addr"}, mac_image_addr, t.img);
                    check({name, ".flt_addr"}, mac_filter_addr, t.flt);
                    check({name, ".pad"}, mac_pad, t.pad);
                    check({name, ".first"}, mac_first, t.first);
                    check({name, ".last"}, mac_last, t.last);
                    if (mac_ready) begin
                        void'(exp_taps.pop_front());
                        if (t.last) begin
                            waiting  = 1'b1;
                            wait_cnt = $urandom_range(0, 3);
                        end
                    end
                end
            end
            if (mem_write_en) begin
                check({name, ".wr_during_mac"}, mac_valid, 0);
                if (exp_wdata.size() == 0) begin
                    check({name, ".extra_write"}, 1, 0);
                end else begin
                    check({name, ".wr_addr"}, mem_write_addr, (out_off + n_written) & AMASK);
                    check({name, ".wr_data"}, mem_write_data, exp_wdata.pop_front());
                end
                n_written++;
            end
            if (done) begin
                seen_done = 1'b1;
                check({name, ".taps_left"}, exp_taps.size(), 0);
                check({name, ".n_writes"}, n_written, n_out);
                if (n_out == 0) check({name, ".done_latency"}, cycles, 0);
            end
            cycles++;
            if (!seen_done) @(negedge clk);
        end
        trigger_accel = 1'b0;
        result_valid  = 1'b0;
        if (!seen_done) check({name, ".done_timeout"}, 0, 1);
        @(negedge clk);
        check({name, ".done_pulse"}, done, 0);
        check({name, ".idle_busy"}, busy, 0);
        check({name, ".idle_valid"}, mac_valid, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".valid"}, mac_valid, 0);
        check({name, ".img_addr"}, mac_image_addr, 0);
        check({name, ".flt_addr"}, mac_filter_addr, 0);
        check({name, ".pad_first_last"}, {mac_pad, mac_first, mac_last}, 0);
        check({name, ".wr"}, {mem_write_en, mem_write_addr, mem_write_data}, 0);
        check({name, ".busy_done"}, {busy, done}, 0);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        image_dim            = 8'd4;
        image_depth          = 9'd2;
        filter_halfsize      = 2'd1;
        filter_stride        = 3'd1;
        filter_memory_offset = 16'h0100;
        trigger_accel        = 1'b1;
        @(negedge clk);
        trigger_accel = 1'b0;
        mac_ready     = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid.pre_valid", mac_valid, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid.async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            result_valid = 1'b1;
            check_all_zero("rst_mid.held");
        end
        result_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid.after_release", {mac_valid, busy, mem_write_en}, 0);
    endtask

    initial begin
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        run_case("dim3_h0",     3,   1, 0, 1, 0, 0, 0);
        run_case("dim3_d2_h1",  3,   2, 1, 1, 0, 1, 5);
        run_case("dim5_s2",     5,   1, 0, 2, 2, 1, 0);
        run_case("dim5_s0",     5,   1, 0, 0, 2, 0, 7);
        run_case("toggle",      4,   2, 1, 1, 1, 1, 3);
        run_case("bias_wrap",   2,   1, 0, 1, 0, 2, 2);
        run_case("dim0",        0,   3, 1, 1, 0, 1, 0);
        run_case("depth0",      4,   0, 1, 1, 0, 1, 0);
        run_case("big_dim",     255, 1, 0, 7, 0, 1, 9);
        run_case("h2_edge",     2,   1, 2, 3, 2, 0, 1);

        reset_mid_run();
        run_case("after_rst",   4,   2, 1, 1, 2, 1, 11);

        for (int i = 0; i < 10; i++) begin
            run_case($sformatf("rand%0d", i),
                     $urandom_range(1, 5), $urandom_range(1, 2), $urandom_range(0, 2),
                     $urandom_range(0, 7), $urandom_range(0, 2), 1,
                     int'($urandom) & DMASK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
